// File: rtl/uart_pkg.sv
// Shared constants for the time-stamp ASCII encoder: FSM states, ASCII codes
// and frame lengths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT
    } enc_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_CR   = 8'h0D;

    localparam int FRAME_LEN_CRLF = 13;
    localparam int FRAME_LEN_LF   = 12;
    localparam int IDX_W          = 4;

endpackage

// File: rtl/bcd_splitter.sv
// Splits a 7-bit value into decimal tens/ones digits, saturating at 99.
module bcd_splitter (
    input  logic [6:0] value,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [6:0] sat;

    always_comb begin
        sat  = (value > 7'd99) ? 7'd99 : value;
        tens = 4'd0;
        for (int k = 1; k < 10; k++) begin
            if (sat >= 7'(10 * k)) tens = 4'(k);
        end
        // ones < 10, so the low nibble alone is exact in mod-16 arithmetic
        ones = sat[3:0] - 4'(tens * 4'd10);
    end

endmodule

// File: rtl/ascii_encoder.sv
// Sends a "HH:MM:SS:CC" time stamp plus line ending to a byte-wide UART,
// one byte per tx_start/tx_done handshake.
module ascii_encoder
    import uart_pkg::*;
#(
    parameter logic [7:0] SEP_CHAR = 8'h3A,
    parameter bit         EOL_CRLF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_req,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic [6:0] csec,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       busy
);

    localparam logic [IDX_W-1:0] LAST_IDX =
        IDX_W'(EOL_CRLF ? FRAME_LEN_CRLF - 1 : FRAME_LEN_LF - 1);

    enc_state_t        state, state_nxt;
    logic [3:0][6:0]   snap;
    logic [3:0][3:0]   tens, ones;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        cur_byte;

    for (genvar g = 0; g < 4; g++) begin : g_split
        bcd_splitter u_split (
            .value (snap[g]),
            .tens  (tens[g]),
            .ones  (ones[g])
        );
    end

    // field f occupies indices 3f (tens), 3f+1 (ones), 3f+2 (separator)
    always_comb begin
        cur_byte = ASCII_LF;
        case (idx)
            4'd0:  cur_byte = ASCII_ZERO + {4'd0, tens[0]};
            4'd1:  cur_byte = ASCII_ZERO + {4'd0, ones[0]};
            4'd3:  cur_byte = ASCII_ZERO + {4'd0, tens[1]};
            4'd4:  cur_byte = ASCII_ZERO + {4'd0, ones[1]};
            4'd6:  cur_byte = ASCII_ZERO + {4'd0, tens[2]};
            4'd7:  cur_byte = ASCII_ZERO + {4'd0, ones[2]};
            4'd9:  cur_byte = ASCII_ZERO + {4'd0, tens[3]};
            4'd10: cur_byte = ASCII_ZERO + {4'd0, ones[3]};
            4'd2, 4'd5, 4'd8: cur_byte = SEP_CHAR;
            4'd11: cur_byte = EOL_CRLF ? ASCII_CR : ASCII_LF;
            default: cur_byte = ASCII_LF;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (send_req) state_nxt = LOAD;
            LOAD: state_nxt = SEND;
            SEND: if (!tx_busy) state_nxt = WAIT;
            WAIT: if (tx_done) state_nxt = (idx == LAST_IDX) ? IDLE : LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // tx_start is the registered SEND->WAIT handshake, so it is a single pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap     <= '0;
            idx      <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
        end else begin
            tx_start <= (state == SEND) && !tx_busy;
            case (state)
                IDLE: if (send_req) begin
                    snap <= {csec, 1'b0, sec, 1'b0, min, 2'b0, hour};
                    idx  <= '0;
                end
                LOAD: tx_data <= cur_byte;
                WAIT: if (tx_done && idx != LAST_IDX) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ascii_encoder.sv
// Bench for ascii_encoder: CRLF and LF instances share stimulus, each with its
// own UART responder and a frame-level reference model.
module tb_ascii_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       send_req = 1'b0;
    logic [4:0] hour = '0;
    logic [5:0] min = '0;
    logic [5:0] sec = '0;
    logic [6:0] csec = '0;
    logic       hold = 1'b0;
    logic [1:0] busy_m = '0;
    logic [1:0] tx_done = '0;
    logic [1:0] tx_busy;
    logic [1:0] tx_start;
    logic [1:0] busy;
    logic [1:0][7:0] tx_data;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    assign tx_busy = {2{hold}} | busy_m;

    ascii_encoder #(.SEP_CHAR(8'h3A), .EOL_CRLF(1'b1)) dut_crlf (
        .clk(clk), .rst(rst), .send_req(send_req),
        .hour(hour), .min(min), .sec(sec), .csec(csec),
        .tx_busy(tx_busy[0]), .tx_done(tx_done[0]),
        .tx_data(tx_data[0]), .tx_start(tx_start[0]), .busy(busy[0])
    );

    ascii_encoder #(.SEP_CHAR(8'h3A), .EOL_CRLF(1'b0)) dut_lf (
        .clk(clk), .rst(rst), .send_req(send_req),
        .hour(hour), .min(min), .sec(sec), .csec(csec),
        .tx_busy(tx_busy[1]), .tx_done(tx_done[1]),
        .tx_data(tx_data[1]), .tx_start(tx_start[1]), .busy(busy[1])
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: byte k of a frame, straight from the frame format rules
    function automatic logic [7:0] frame_byte(input int h, input int m, input int s,
                                              input int c, input bit crlf, input int k);
        int v[4];
        int f;
        v = '{h, m, s, c};
        if (k >= 11) return (k == 11 && crlf) ? 8'h0D : 8'h0A;
        if (k % 3 == 2) return 8'h3A;
        f = v[k / 3];
        if (f > 99) f = 99;
        return (k % 3 == 0) ? 8'(48 + f / 10) : 8'(48 + f % 10);
    endfunction

    function automatic int flen(input int i);
        return (i == 0) ? 13 : 12;
    endfunction

    // UART responder: busy for 1..4 cycles after each tx_start, then tx_done
    int cnt[2];
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            tx_done[i] = 1'b0;
            if (!rst) cnt[i] = 0;
            else begin
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) tx_done[i] = 1'b1;
                end
                if (tx_start[i]) cnt[i] = $urandom_range(1, 4);
            end
            busy_m[i] = (cnt[i] > 0);
        end
    end

    // Model state, one frame at a time per instance
    bit   mb[2];
    bit   acc;
    int   sent[2], dones[2], starts[2], nlog[2];
    int   sh[2], sm[2], ss[2], sc[2];
    logic [7:0] logb[2][16];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                check($sformatf("rst_busy%0d", i), int'(busy[i]), 0);
                check($sformatf("rst_start%0d", i), int'(tx_start[i]), 0);
                mb[i] = 1'b0;
            end else begin
                acc = send_req && !mb[i];
                check($sformatf("busy%0d", i), int'(busy[i]), int'(mb[i]));
                if (tx_start[i]) begin
                    starts[i]++;
                    if (!mb[i] || sent[i] >= flen(i))
                        check($sformatf("spurious_start%0d", i), 1, 0);
                    else begin
                        check($sformatf("byte%0d_%0d", i, sent[i]), int'(tx_data[i]),
                              int'(frame_byte(sh[i], sm[i], ss[i], sc[i], i == 0, sent[i])));
                        if (nlog[i] < 16) logb[i][nlog[i]] = tx_data[i];
                        nlog[i]++;
                        sent[i]++;
                    end
                end
                if (tx_done[i] && mb[i]) begin
                    dones[i]++;
                    if (dones[i] == flen(i)) mb[i] = 1'b0;
                end
                if (acc) begin
                    sh[i] = int'(hour); sm[i] = int'(min);
                    ss[i] = int'(sec);  sc[i] = int'(csec);
                    sent[i] = 0; dones[i] = 0; nlog[i] = 0;
                    mb[i] = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int h, input int m, input int s, input int c);
        step();
        hour = 5'(h); min = 6'(m); sec = 6'(s); csec = 7'(c);
        send_req = 1'b1;
        step();
        send_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy != 2'b00 && n < 2000) begin
            step();
            n++;
        end
        step();
        check(name, int'(n < 2000), 1);
    endtask

    logic [7:0] exp30[13] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35,
                              8'h36, 8'h3A, 8'h37, 8'h38, 8'h0D, 8'h0A};
    logic [7:0] exp30lf[12] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35,
                                8'h36, 8'h3A, 8'h37, 8'h38, 8'h0A};
    logic [7:0] exp31[12] = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30,
                              8'h30, 8'h3A, 8'h30, 8'h30, 8'h0A};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s0;
        int s1;
        bit found;

        repeat (3) step();
        check("reset_txdata0", int'(tx_data[0]), 0);
        check("reset_txdata1", int'(tx_data[1]), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b1;
        repeat (2) step();

        // Reference frame and first-byte latency with an idle UART
        hour = 5'd12; min = 6'd34; sec = 6'd56; csec = 7'd78;
        send_req = 1'b1;
        check("lat_c0", int'(tx_start), 0);
        step();
        send_req = 1'b0;
        check("lat_c1", int'(tx_start), 0);
        check("lat_busy", int'(busy), 3);
        step();
        check("lat_c2", int'(tx_start), 0);
        step();
        check("lat_c3", int'(tx_start), 3);
        wait_idle("idle_ref");
        check("ref_len_crlf", nlog[0], 13);
        check("ref_len_lf", nlog[1], 12);
        for (int k = 0; k < 13; k++) check($sformatf("ref_crlf_%0d", k), int'(logb[0][k]), int'(exp30[k]));
        for (int k = 0; k < 12; k++) check($sformatf("ref_lf_%0d", k), int'(logb[1][k]), int'(exp30lf[k]));
        check("hold_txdata", int'(tx_data[0]), 8'h0A);

        // All-zero frame on the LF instance
        send(0, 0, 0, 0);
        wait_idle("idle_zero");
        check("zero_len_lf", nlog[1], 12);
        for (int k = 0; k < 12; k++) check($sformatf("zero_lf_%0d", k), int'(logb[1][k]), int'(exp31[k]));

        // Out-of-range centiseconds saturate to 99
        send(1, 2, 3, 127);
        wait_idle("idle_sat");
        check("sat_c9", int'(logb[0][9]), 8'h39);
        check("sat_c10", int'(logb[0][10]), 8'h39);
        check("sat_lf_c10", int'(logb[1][10]), 8'h39);

        // UART busy before the first byte withholds tx_start
        hold = 1'b1;
        send(5, 6, 7, 8);
        for (int k = 0; k < 20; k++) begin
            step();
            check("held_start", int'(tx_start), 0);
        end
        hold = 1'b0;
        check("release_c0", int'(tx_start), 0);
        step();
        check("release_c1", int'(tx_start), 3);
        wait_idle("idle_hold");

        // Second request and new inputs mid-frame are ignored
        send(9, 10, 11, 12);
        n = 0;
        while (sent[0] < 5 && n < 500) begin step(); n++; end
        check("reach_byte5", int'(n < 500), 1);
        hour = 5'd23; min = 6'd59; sec = 6'd58; csec = 7'd97;
        send_req = 1'b1;
        step();
        send_req = 1'b0;
        wait_idle("idle_ignore");
        check("ignore_len", nlog[0], 13);
        check("ignore_h1", int'(logb[0][1]), 8'h39);
        check("ignore_m0", int'(logb[0][3]), 8'h31);

        // Request coinciding with the final tx_done is dropped
        send(20, 21, 22, 23);
        found = 1'b0;
        n = 0;
        while (!found && n < 500) begin
            step();
            n++;
            if (tx_done[0] && dones[0] == 12 && mb[0]) begin
                found = 1'b1;
                send_req = 1'b1;
                step();
                send_req = 1'b0;
                step();
                check("last_done_req_busy", int'(busy[0]), 0);
            end
        end
        check("last_done_found", int'(found), 1);
        wait_idle("idle_lastdone");

        // Reset mid-frame aborts immediately
        send(1, 1, 1, 1);
        n = 0;
        while (sent[0] < 7 && n < 500) begin step(); n++; end
        check("reach_byte7", int'(n < 500), 1);
        #1 rst = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_start", int'(tx_start), 0);
        check("abort_txdata", int'(tx_data[0]), 0);
        step();
        step();
        rst = 1'b1;
        s0 = starts[0]; s1 = starts[1];
        repeat (20) step();
        check("abort_quiet0", starts[0], s0);
        check("abort_quiet1", starts[1], s1);
        send(2, 3, 4, 5);
        wait_idle("idle_after_rst");
        check("rst_full_crlf", nlog[0], 13);
        check("rst_full_lf", nlog[1], 12);

        // Random requests and inputs, including requests while busy
        for (int k = 0; k < 3000; k++) begin
            step();
            hour = 5'($urandom); min = 6'($urandom);
            sec = 6'($urandom);  csec = 7'($urandom);
            send_req = ($urandom_range(0, 9) == 0);
        end
        step();
        send_req = 1'b0;
        wait_idle("idle_random");
        check("random_frames_seen", int'(starts[0] > 100), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
